clk_gate_ctrl: RTL and testbench
================================

CLK_GATE_CTRL -- requirements
Module: clk_gate_ctrl

Interface
REQ-001 Parameter WAKE_CYC, default 2, number of cycles the gate stays open in WAKE before wake_ack; legal range 1..15.
REQ-002 Parameter STAT_W, default 16, width of the gated-cycle statistics counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset is synchronous and active-high.
REQ-005 cfg_en  input  1  auto-gating enable; 0 forces the clock on.
REQ-006 idle_thresh  input  8  consecutive idle cycles required before gating; 0 is treated as 1.
REQ-007 busy  input  1  downstream logic activity; 1 means the clock is needed.
REQ-008 wake_req  input  1  external wake request, level-sensitive, synchronous to clk.
REQ-009 scan_en  input  1  scan/test enable.
REQ-010 stat_clr  input  1  single-cycle clear of the statistics counter.
REQ-011 gate_en  output  1  registered enable to the clock-gate cell EN pin.
REQ-012 gate_se  output  1  test enable to the clock-gate cell SE pin.
REQ-013 sleep  output  1  registered; 1 while the clock is gated.
REQ-014 wake_ack  output  1  registered one-cycle pulse when a wake sequence completes.
REQ-015 gated_cnt  output  STAT_W  saturating count of cycles spent in GATED.

Function
REQ-016 States: RUN, GATED, WAKE; encoding is free.
REQ-017 RUN: gate_en=1, sleep=0; idle_cnt (8 bit) increments on each edge sampling cfg_en=1, busy=0, wake_req=0, else clears to 0.
REQ-018 RUN->GATED on the edge where idle_cnt+1 reaches max(idle_thresh,1); idle_cnt clears; gate_en=0 and sleep=1 from that edge.
REQ-019 idle_thresh changes take effect immediately; if idle_cnt already >= new threshold, the next qualifying idle cycle triggers GATED.
REQ-020 GATED: gate_en=0, sleep=1; exits to WAKE on the first edge sampling busy=1 or wake_req=1 or cfg_en=0; gate_en=1 and sleep=0 from that edge.
REQ-021 WAKE: gate_en=1; wake_cnt counts WAKE_CYC edges; busy, wake_req and cfg_en are ignored in WAKE.
REQ-022 WAKE->RUN on the WAKE_CYC-th edge in WAKE; wake_ack=1 for exactly the first RUN cycle and 0 otherwise.
REQ-023 RUN does not re-enter GATED earlier than a full fresh idle_thresh count after WAKE.
REQ-024 Simultaneous busy=1 and last idle cycle in RUN: busy wins; remain RUN, idle_cnt clears.
REQ-025 gate_se = scan_en, combinational; the FSM keeps running independently of scan_en.
REQ-026 gated_cnt increments by 1 on every edge with state GATED, saturates at all-ones, never wraps.
REQ-027 stat_clr=1 sets gated_cnt to 0 on that edge, taking priority over a simultaneous increment.
REQ-028 No combinational path from busy, wake_req or cfg_en to gate_en.

Reset
REQ-029 rst=1 at an edge: state=RUN, idle_cnt=0, wake_cnt=0, gated_cnt=0, gate_en=1, sleep=0, wake_ack=0.
REQ-030 Reset asserted in GATED or WAKE returns to RUN with gate_en=1 on that edge; no wake_ack is generated.
REQ-031 gate_se follows scan_en during reset.

Verification
REQ-032 cfg_en=1, idle_thresh=4, busy=0 from cycle 0 -> gate_en falls after the 4th edge, sleep=1, gated_cnt increments each cycle.
REQ-033 In GATED, busy=1 for one cycle -> gate_en=1 on the next edge; wake_ack pulses once after exactly 2 edges (WAKE_CYC=2); RUN restarts the idle count.
REQ-034 idle_thresh=4, busy pulses 1 every 3rd cycle -> gate_en stays 1 throughout and gated_cnt stays 0.
REQ-035 idle_thresh=0 with busy=0 -> GATED after 1 idle edge; cfg_en dropped to 0 in GATED -> WAKE, then RUN with no re-gating while cfg_en=0.
REQ-036 STAT_W=4, hold GATED for 20 cycles -> gated_cnt saturates at 15; stat_clr together with an increment -> gated_cnt=0.
REQ-037 rst=1 mid-WAKE -> next cycle gate_en=1, sleep=0, wake_ack=0, gated_cnt=0; scan_en toggling -> gate_se tracks it in the same cycle.

Source files
------------

// File: rtl/clk_gate_ctrl.sv
// Idle-driven clock-gate controller: gates the downstream clock after a run of idle cycles
// and reopens it through a fixed-length wake window, with a saturating gated-cycle counter.
module clk_gate_ctrl #(
    parameter int unsigned WAKE_CYC = 2,
    parameter int unsigned STAT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_en,
    input  logic [7:0]        idle_thresh,
    input  logic              busy,
    input  logic              wake_req,
    input  logic              scan_en,
    input  logic              stat_clr,
    output logic              gate_en,
    output logic              gate_se,
    output logic              sleep,
    output logic              wake_ack,
    output logic [STAT_W-1:0] gated_cnt
);

    typedef enum logic [1:0] {StRun, StGated, StWake} state_e;

    localparam logic [3:0] WakeLast = 4'(WAKE_CYC);

    state_e      state;
    logic [7:0]  idle_cnt;
    logic [3:0]  wake_cnt;
    logic [7:0]  thresh_eff;
    logic [8:0]  idle_next;
    logic [3:0]  wake_next;
    logic        idle_cycle;
    logic        wake_cond;

    assign thresh_eff = (idle_thresh == 8'd0) ? 8'd1 : idle_thresh;
    assign idle_next  = {1'b0, idle_cnt} + 9'd1;
    assign wake_next  = wake_cnt + 4'd1;
    assign idle_cycle = cfg_en & ~busy & ~wake_req;
    assign wake_cond  = busy | wake_req | ~cfg_en;

    // Test enable bypasses the FSM entirely so scan can always clock the gated domain.
    assign gate_se = scan_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= StRun;
            idle_cnt <= 8'd0;
            wake_cnt <= 4'd0;
            gate_en  <= 1'b1;
            sleep    <= 1'b0;
            wake_ack <= 1'b0;
        end else begin
            wake_ack <= 1'b0;
            unique case (state)
                StRun: begin
                    if (!idle_cycle) begin
                        idle_cnt <= 8'd0;
                    end else if (idle_next >= {1'b0, thresh_eff}) begin
                        // >= so a lowered threshold triggers on the next idle cycle
                        state    <= StGated;
                        idle_cnt <= 8'd0;
                        gate_en  <= 1'b0;
                        sleep    <= 1'b1;
                    end else begin
                        idle_cnt <= idle_next[7:0];
                    end
                end
                StGated: begin
                    if (wake_cond) begin
                        state    <= StWake;
                        wake_cnt <= 4'd0;
                        gate_en  <= 1'b1;
                        sleep    <= 1'b0;
                    end
                end
                StWake: begin
                    if (wake_next == WakeLast) begin
                        state    <= StRun;
                        wake_cnt <= 4'd0;
                        idle_cnt <= 8'd0;
                        wake_ack <= 1'b1;
                    end else begin
                        wake_cnt <= wake_next;
                    end
                end
                default: begin
                    state    <= StRun;
                    idle_cnt <= 8'd0;
                    wake_cnt <= 4'd0;
                    gate_en  <= 1'b1;
                    sleep    <= 1'b0;
                end
            endcase
        end
    end

    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            gated_cnt <= '0;
        end else if (state == StGated && !(&gated_cnt)) begin
            gated_cnt <= gated_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Table-driven bench for clk_gate_ctrl: hand-derived per-edge expectations fed through a
// scoreboard queue, plus short hand-written latency and pulse-width sequences.
module tb_clk_gate_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, cfg_en, busy, wake_req, scan_en, stat_clr;
    logic [7:0] idle_thresh;

    logic        gate_en, gate_se, sleep, wake_ack;
    logic [15:0] gated_cnt;
    logic        s_gate_en, s_gate_se, s_sleep, s_wake_ack;
    logic [3:0]  s_gated_cnt;

    clk_gate_ctrl #(.WAKE_CYC(2), .STAT_W(16)) u_dut (
        .clk(clk), .rst(rst), .cfg_en(cfg_en), .idle_thresh(idle_thresh), .busy(busy),
        .wake_req(wake_req), .scan_en(scan_en), .stat_clr(stat_clr), .gate_en(gate_en),
        .gate_se(gate_se), .sleep(sleep), .wake_ack(wake_ack), .gated_cnt(gated_cnt)
    );

    clk_gate_ctrl #(.WAKE_CYC(2), .STAT_W(4)) u_dut_small (
        .clk(clk), .rst(rst), .cfg_en(cfg_en), .idle_thresh(idle_thresh), .busy(busy),
        .wake_req(wake_req), .scan_en(scan_en), .stat_clr(stat_clr), .gate_en(s_gate_en),
        .gate_se(s_gate_se), .sleep(s_sleep), .wake_ack(s_wake_ack), .gated_cnt(s_gated_cnt)
    );

    typedef struct {
        logic       rst, cfg, b, w, se, clr;
        logic [7:0] thr;
        logic       ge, sl, ack;
        int         cnt;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic void add(input logic r, input logic cfg, input logic [7:0] thr,
                                input logic b, input logic w, input logic clr,
                                input logic ge, input logic sl, input logic ack, input int cnt);
        vec_t v;
        v.rst = r; v.cfg = cfg; v.thr = thr; v.b = b; v.w = w; v.clr = clr;
        v.se  = (vecs.size() % 3 == 1);
        v.ge  = ge; v.sl = sl; v.ack = ack; v.cnt = cnt;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        vec_t v;
        int   edges;
        int   acks;

        rst = 1'b1; cfg_en = 1'b1; idle_thresh = 8'd4; busy = 1'b0;
        wake_req = 1'b0; scan_en = 1'b0; stat_clr = 1'b0;

        // reset, then thresh=4 idle -> gated after 4th edge
        add(1, 1, 4, 0, 0, 0, 1, 0, 0, 0);
        add(0, 1, 4, 0, 0, 0, 1, 0, 0, 0);
        add(0, 1, 4, 0, 0, 0, 1, 0, 0, 0);
        add(0, 1, 4, 0, 0, 0, 1, 0, 0, 0);
        add(0, 1, 4, 0, 0, 0, 0, 1, 0, 0);
        add(0, 1, 4, 0, 0, 0, 0, 1, 0, 1);
        add(0, 1, 4, 0, 0, 0, 0, 1, 0, 2);
        // busy wakes; ack two edges later; fresh idle count
        add(0, 1, 4, 1, 0, 0, 1, 0, 0, 3);
        add(0, 1, 4, 0, 0, 0, 1, 0, 0, 3);
        add(0, 1, 4, 0, 0, 0, 1, 0, 1, 3);
        add(0, 1, 4, 0, 0, 0, 1, 0, 0, 3);
        add(0, 1, 4, 0, 0, 0, 1, 0, 0, 3);
        add(0, 1, 4, 0, 0, 0, 1, 0, 0, 3);
        add(0, 1, 4, 0, 0, 0, 0, 1, 0, 3);
        add(0, 1, 4, 0, 0, 0, 0, 1, 0, 4);
        // cfg_en low wakes and holds the clock on
        add(0, 0, 0, 0, 0, 0, 1, 0, 0, 5);
        add(0, 0, 0, 0, 0, 0, 1, 0, 0, 5);
        add(0, 0, 0, 0, 0, 0, 1, 0, 1, 5);
        for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0, 0, 1, 0, 0, 5);
        // thresh 0 acts as 1; wake_req wakes and is ignored inside WAKE
        add(0, 1, 0, 0, 0, 0, 0, 1, 0, 5);
        add(0, 1, 0, 0, 0, 0, 0, 1, 0, 6);
        add(0, 1, 0, 0, 1, 0, 1, 0, 0, 7);
        add(0, 1, 0, 0, 1, 0, 1, 0, 0, 7);
        add(0, 1, 0, 0, 0, 0, 1, 0, 1, 7);
        add(0, 1, 0, 0, 0, 0, 0, 1, 0, 7);
        add(0, 1, 0, 1, 0, 0, 1, 0, 0, 8);
        add(0, 1, 0, 0, 0, 0, 1, 0, 0, 8);
        add(0, 1, 0, 0, 0, 0, 1, 0, 1, 8);
        // busy every 3rd cycle never lets a thresh of 4 complete
        for (int i = 0; i < 12; i++) add(0, 1, 4, logic'(i % 3 == 2), 0, 0, 1, 0, 0, 8);
        // busy on the would-be last idle cycle wins
        for (int i = 0; i < 3; i++) add(0, 1, 4, 0, 0, 0, 1, 0, 0, 8);
        add(0, 1, 4, 1, 0, 0, 1, 0, 0, 8);
        for (int i = 0; i < 3; i++) add(0, 1, 4, 0, 0, 0, 1, 0, 0, 8);
        add(0, 1, 4, 0, 0, 0, 0, 1, 0, 8);
        add(0, 1, 4, 1, 0, 0, 1, 0, 0, 9);
        add(0, 1, 4, 0, 0, 0, 1, 0, 0, 9);
        add(0, 1, 4, 0, 0, 0, 1, 0, 1, 9);
        // lowering thresh below the running idle count gates on the next idle cycle
        for (int i = 0; i < 5; i++) add(0, 1, 8, 0, 0, 0, 1, 0, 0, 9);
        add(0, 1, 3, 0, 0, 0, 0, 1, 0, 9);
        // long GATED stretch: small instance saturates at 15
        for (int i = 1; i <= 20; i++) add(0, 1, 3, 0, 0, 0, 0, 1, 0, 9 + i);
        add(0, 1, 3, 0, 0, 1, 0, 1, 0, 0);
        add(0, 1, 3, 0, 0, 0, 0, 1, 0, 1);
        // reset mid-WAKE: back to RUN, no ack, counter cleared
        add(0, 1, 3, 1, 0, 0, 1, 0, 0, 2);
        add(0, 1, 3, 0, 0, 0, 1, 0, 0, 2);
        add(1, 1, 3, 0, 0, 0, 1, 0, 0, 0);
        add(0, 1, 4, 0, 0, 0, 1, 0, 0, 0);
        add(0, 1, 4, 0, 0, 0, 1, 0, 0, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst; cfg_en = vecs[i].cfg; idle_thresh = vecs[i].thr;
            busy = vecs[i].b; wake_req = vecs[i].w; scan_en = vecs[i].se;
            stat_clr = vecs[i].clr;
            sb.push_back(vecs[i]);
            #1;
            check($sformatf("row%0d gate_se", i), int'(gate_se), int'(vecs[i].se));
            check($sformatf("row%0d small gate_se", i), int'(s_gate_se), int'(vecs[i].se));
            @(posedge clk);
            #1;
            v = sb.pop_front();
            check($sformatf("row%0d gate_en", i), int'(gate_en), int'(v.ge));
            check($sformatf("row%0d sleep", i), int'(sleep), int'(v.sl));
            check($sformatf("row%0d wake_ack", i), int'(wake_ack), int'(v.ack));
            check($sformatf("row%0d gated_cnt", i), int'(gated_cnt), v.cnt);
            check($sformatf("row%0d small gated_cnt", i), int'(s_gated_cnt),
                  (v.cnt > 15) ? 15 : v.cnt);
            check($sformatf("row%0d small gate_en", i), int'(s_gate_en), int'(v.ge));
        end

        // thresh=2 from reset: sleep must rise exactly 2 edges later
        @(negedge clk);
        rst = 1'b1; scan_en = 1'b0; busy = 1'b0; wake_req = 1'b0; stat_clr = 1'b0;
        cfg_en = 1'b1;
        @(negedge clk);
        rst = 1'b0; idle_thresh = 8'd2;
        edges = 0;
        while (!sleep && edges < 10) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check("thresh2 gating latency", edges, 2);

        // one-cycle wake_req: exactly one ack pulse within the window
        @(negedge clk);
        wake_req = 1'b1;
        @(negedge clk);
        wake_req = 1'b0; cfg_en = 1'b0;
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (wake_ack) acks++;
        end
        check("single wake ack pulse", acks, 1);
        check("clock on after wake with cfg_en=0", int'(gate_en), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
